count_uart_tx: RTL and testbench
================================

COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 SHALL have parameter pClkDiv, default 416, clocks per serial bit (48 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port wClk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port wRst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port wInData, input, 8, byte to transmit (e.g. upstream counter value).
REQ-005 SHALL have port wInValid, input, 1, upstream offers wInData.
REQ-006 SHALL have port rInReady, output, 1, registered; block can accept a byte.
REQ-007 SHALL have port rTxd, output, 1, registered serial line; idle level 1.
REQ-008 SHALL have port rBusy, output, 1, registered; high while a frame is on the line.

Function
REQ-009 SHALL implement an FSM with states IDLE, START, DATA, PARITY (only if the REQ-024 macro is defined), STOP.
REQ-010 SHALL accept a byte on the rising edge where wInValid=1 and rInReady=1; wInData is captured into an internal shift register on that edge.
REQ-011 SHALL assert rInReady only in IDLE; rInReady SHALL drop on the edge after acceptance.
REQ-012 SHALL drive the start bit (rTxd=0) from the first clock after acceptance: latency of 1 clock from acceptance to the falling line edge.
REQ-013 SHALL hold every bit (start, each data, parity, stop) for exactly pClkDiv clocks, timed by a baud counter of ceil(log2(pClkDiv)) bits that reloads at each bit boundary.
REQ-014 SHALL send data LSB first, bit 0 through bit 7, tracked by a 3-bit index that terminates DATA after index 7, with no wrap into a 9th bit.
REQ-015 SHALL send a stop bit of rTxd=1, then enter IDLE with rInReady=1 on the following clock.
REQ-016 SHALL accept a new byte on the first IDLE clock when wInValid is held high, giving exactly 1 clock of idle mark between back-to-back frames.
REQ-017 SHALL ignore changes to wInData or wInValid while not in IDLE; the frame in flight is unaffected.
REQ-018 SHALL assert rBusy from the START state through the last STOP clock, and deassert it in IDLE.
REQ-019 SHALL make frame length exactly 10*pClkDiv clocks, or 11*pClkDiv with parity enabled.
REQ-020 SHALL keep rTxd glitch-free and driven only from a flop.

Reset
REQ-021 SHALL, while wRst=1, force state IDLE, rTxd=1, rBusy=0, rInReady=1, baud counter 0, bit index 0, shift register 0, independent of wClk.
REQ-022 SHALL abort a frame immediately on reset asserted mid-frame: line goes high at once, and no partial frame resumes after release.
REQ-023 SHALL allow a byte to be accepted on the first rising edge after wRst falls if wInValid=1.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP transmitting the even parity bit (XOR of the 8 data bits) for pClkDiv clocks; frame format is 8E1.
REQ-025 SHALL, with UART_TX_PARITY_EN undefined, compile out the PARITY state and parity logic, so that DATA goes directly to STOP; frame format is 8N1.

Verification (pClkDiv=4 unless stated)
REQ-026 SHALL cover: reset pulse then idle -> rTxd=1, rInReady=1, rBusy=0, and no line activity for 100 clocks.
REQ-027 SHALL cover: accept 0xA5 -> rTxd reads 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks, with the start bit beginning 1 clock after acceptance and 40 clocks per frame.
REQ-028 SHALL cover: wInValid held high with 0x00 then 0xFF -> two frames separated by exactly 1 idle clock; rInReady high for exactly 1 clock between frames.
REQ-029 SHALL cover: wRst pulsed during data bit 3 of 0x0F -> rTxd=1 and rInReady=1 immediately; the next accepted byte 0x3C is sent intact.
REQ-030 SHALL cover: with UART_TX_PARITY_EN, bytes 0x01 and 0x03 -> parity bits 1 and 0 respectively, at 44 clocks per frame.
REQ-031 SHALL cover: pClkDiv=2, wInData toggled every clock during a frame of 0x55 -> line pattern matches 0x55 only, with bits 2 clocks wide.

Source files
------------

// File: rtl/count_uart_tx.sv
// count_uart_tx
// Serial transmitter for a byte stream, for example a free-running counter
// value being dumped to a terminal.
// Each accepted byte is sent as one frame: a start bit, 8 data bits LSB first,
// an optional even parity bit, and a stop bit. Every bit lasts pClkDiv clocks.
//
// Parameters
//   pClkDiv   clocks per serial bit (2..65535), default 416 = 48 MHz / 115200
//
// Ports
//   wClk      sole clock, rising edge
//   wRst      asynchronous active-high reset; aborts any frame in flight
//   wInData   byte to transmit, captured when wInValid and rInReady are both high
//   wInValid  upstream offers wInData
//   rInReady  registered; high only while idle, i.e. a byte can be taken
//   rTxd      registered serial line, idles at 1
//   rBusy     registered; high for the whole frame, start through stop
//
// Build option
//   UART_TX_PARITY_EN  when defined, an even parity bit follows the data bits
//                      (8E1 frames). When undefined the frame is 8N1.

module count_uart_tx #(
   parameter int pClkDiv = 416
) (
   input  logic       wClk,
   input  logic       wRst,
   input  logic [7:0] wInData,
   input  logic       wInValid,
   output logic       rInReady,
   output logic       rTxd,
   output logic       rBusy
);

   localparam int cntW = $clog2(pClkDiv);
   localparam logic [cntW-1:0] cntLoad = cntW'(pClkDiv - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;
`endif

   txState_t        state;
   txState_t        stateNext;
   logic [cntW-1:0] baudCnt;
   logic [cntW-1:0] baudNext;
   logic [2:0]      bitIdx;
   logic [2:0]      bitIdxNext;
   logic [7:0]      shiftReg;
   logic [7:0]      shiftNext;
   logic            txdNext;
   logic            busyNext;
   logic            readyNext;
   logic            bitDone;
`ifdef UART_TX_PARITY_EN
   logic            parityBit;
   logic            parityNext;
`endif

   // The baud counter is loaded with pClkDiv-1 on every bit boundary and counts
   // down, so reaching zero marks the last clock of the bit currently on the line.
   assign bitDone = (baudCnt == '0);

   // State and output register. All outputs come straight from flops so the line
   // never glitches. Reset parks everything at the idle-line values at once,
   // which is also what kills a frame caught half way out.
   always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         rTxd     <= 1'b1;
         rBusy    <= 1'b0;
         rInReady <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         rTxd     <= txdNext;
         rBusy    <= busyNext;
         rInReady <= readyNext;
`ifdef UART_TX_PARITY_EN
         parityBit <= parityNext;
`endif
      end
   end

   // Next-state and next-output logic. The value loaded into rTxd at a bit
   // boundary is the level of the bit that starts on that edge, so the line
   // level always matches the state one clock later. Data shifts right, so the
   // bit going out is always shiftReg[0] and the one after it is shiftReg[1].
   // Parity is taken from the whole byte at acceptance because the shift
   // register no longer holds all eight bits by the time it is sent.
   always_comb begin
      stateNext  = state;
      baudNext   = baudCnt;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      txdNext    = rTxd;
      busyNext   = rBusy;
      readyNext  = rInReady;
`ifdef UART_TX_PARITY_EN
      parityNext = parityBit;
`endif
      case (state)
         IDLE: begin
            if (wInValid && rInReady) begin
               stateNext  = START;
               baudNext   = cntLoad;
               bitIdxNext = '0;
               shiftNext  = wInData;
               txdNext    = 1'b0;
               busyNext   = 1'b1;
               readyNext  = 1'b0;
`ifdef UART_TX_PARITY_EN
               parityNext = ^wInData;
`endif
            end
         end
         START: begin
            if (bitDone) begin
               stateNext = DATA;
               baudNext  = cntLoad;
               txdNext   = shiftReg[0];
            end else begin
               baudNext = baudCnt - cntW'(1);
            end
         end
         DATA: begin
            if (bitDone) begin
               baudNext = cntLoad;
               if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  stateNext = PARITY;
                  txdNext   = parityBit;
`else
                  stateNext = STOP;
                  txdNext   = 1'b1;
`endif
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
                  shiftNext  = shiftReg >> 1;
                  txdNext    = shiftReg[1];
               end
            end else begin
               baudNext = baudCnt - cntW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bitDone) begin
               stateNext = STOP;
               baudNext  = cntLoad;
               txdNext   = 1'b1;
            end else begin
               baudNext = baudCnt - cntW'(1);
            end
         end
`endif
         STOP: begin
            if (bitDone) begin
               stateNext = IDLE;
               baudNext  = '0;
               txdNext   = 1'b1;
               busyNext  = 1'b0;
               readyNext = 1'b1;
            end else begin
               baudNext = baudCnt - cntW'(1);
            end
         end
         default: begin
            stateNext = IDLE;
            baudNext  = '0;
            txdNext   = 1'b1;
            busyNext  = 1'b0;
            readyNext = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb_count_uart_tx
// Bench for count_uart_tx. Instance 0 runs at 4 clocks per bit, instance 1 at
// 2 clocks per bit; both share clock and reset. A frame-level model predicts the
// line, busy and ready outputs of both instances every cycle, and directed
// scenarios add literal expectations for specific frames.

module tb_count_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [10:0] SEQ_A5 = 11'b10101001010;
   localparam logic [10:0] SEQ_3C = 11'b10001111000;
   localparam logic [10:0] SEQ_55 = 11'b10010101010;
   localparam logic        SLOT9_01 = 1'b1;
   localparam logic        SLOT9_03 = 1'b0;
`else
   localparam int NB = 10;
   localparam logic [10:0] SEQ_A5 = 11'b01101001010;
   localparam logic [10:0] SEQ_3C = 11'b01001111000;
   localparam logic [10:0] SEQ_55 = 11'b01010101010;
   localparam logic        SLOT9_01 = 1'b1;
   localparam logic        SLOT9_03 = 1'b1;
`endif

   logic       wClk = 1'b0;
   logic       wRst = 1'b0;
   logic [7:0] wInData [2];
   logic [1:0] wInValid;
   logic [1:0] rInReady;
   logic [1:0] rTxd;
   logic [1:0] rBusy;

   int assertCount = 0;
   int failCount   = 0;

   // Frame-level model state per instance.
   int          mD [2] = '{4, 2};
   bit          mBusy [2] = '{1'b0, 1'b0};
   bit          mReady [2] = '{1'b1, 1'b1};
   int          mPos [2] = '{0, 0};
   logic [10:0] mFrame [2];

   // Recording buffers for directed scenarios.
   logic recTxd [256];
   logic recBusy [256];
   logic recReady [256];
   int   busyCnt;
   int   readyCnt;

   count_uart_tx #(.pClkDiv(4)) dut0 (
      .wClk     (wClk),
      .wRst     (wRst),
      .wInData  (wInData[0]),
      .wInValid (wInValid[0]),
      .rInReady (rInReady[0]),
      .rTxd     (rTxd[0]),
      .rBusy    (rBusy[0])
   );

   count_uart_tx #(.pClkDiv(2)) dut1 (
      .wClk     (wClk),
      .wRst     (wRst),
      .wInData  (wInData[1]),
      .wInValid (wInValid[1]),
      .rInReady (rInReady[1]),
      .rTxd     (rTxd[1]),
      .rBusy    (rBusy[1])
   );

   always #5 wClk = ~wClk;

   // Model: a frame is a list of NB line levels, each lasting D clocks, that
   // starts on the clock after the byte is taken; the block is ready again on
   // the clock the list runs out.
   always @(posedge wClk or posedge wRst) begin
      for (int k = 0; k < 2; k++) begin
         if (wRst) begin
            mBusy[k]  = 1'b0;
            mReady[k] = 1'b1;
            mPos[k]   = 0;
         end else if (mReady[k] && wInValid[k]) begin
            mFrame[k] = '1;
            mFrame[k][0] = 1'b0;
            for (int b = 0; b < 8; b++) mFrame[k][1 + b] = wInData[k][b];
`ifdef UART_TX_PARITY_EN
            mFrame[k][9] = ^wInData[k];
`endif
            mBusy[k]  = 1'b1;
            mReady[k] = 1'b0;
            mPos[k]   = 0;
         end else if (mBusy[k]) begin
            mPos[k]++;
            if (mPos[k] == NB * mD[k]) begin
               mBusy[k]  = 1'b0;
               mReady[k] = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Compare process: every cycle, both instances against the model.
   always @(negedge wClk) begin
      for (int k = 0; k < 2; k++) begin
         logic e;
         e = mBusy[k] ? mFrame[k][mPos[k] / mD[k]] : 1'b1;
         checkOutput($sformatf("modelTxd%0d", k), {31'd0, rTxd[k]}, {31'd0, e});
         checkOutput($sformatf("modelBusy%0d", k), {31'd0, rBusy[k]}, {31'd0, mBusy[k]});
         checkOutput($sformatf("modelReady%0d", k), {31'd0, rInReady[k]}, {31'd0, mReady[k]});
      end
   end

   // Offer one byte to instance k once it is ready; returns on the negedge
   // right after the accepting edge with wInValid dropped.
   task automatic applyStimulus(input int k, input logic [7:0] data);
      int w = 0;
      while (rInReady[k] !== 1'b1 && w < 200) begin
         @(negedge wClk);
         w++;
      end
      if (w >= 200) checkOutput("readyTimeout", 32'd0, 32'd1);
      wInData[k]  = data;
      wInValid[k] = 1'b1;
      @(posedge wClk);
      @(negedge wClk);
      wInValid[k] = 1'b0;
   endtask

   // Sample instance k on n consecutive negedges starting with the current one.
   task automatic recordFrame(input int k, input int n, input int dropAt, input bit toggle);
      busyCnt  = 0;
      readyCnt = 0;
      for (int i = 0; i < n; i++) begin
         recTxd[i]   = rTxd[k];
         recBusy[i]  = rBusy[k];
         recReady[i] = rInReady[k];
         if (rBusy[k] === 1'b1) busyCnt++;
         if (rInReady[k] === 1'b1) readyCnt++;
         if (i == dropAt) wInValid[k] = 1'b0;
         if (toggle) wInData[k] = ~wInData[k];
         @(negedge wClk);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [10:0] seq;
      int idleAct;
      wInValid   = 2'b00;
      wInData[0] = 8'h00;
      wInData[1] = 8'h00;

      // Reset is asynchronous: outputs take idle values before any clock edge.
      #1 wRst = 1'b1;
      #1;
      $display("[TB] reset asserted");
      checkOutput("rstTxd", {31'd0, rTxd[0]}, 32'd1);
      checkOutput("rstReady", {31'd0, rInReady[0]}, 32'd1);
      checkOutput("rstBusy", {31'd0, rBusy[0]}, 32'd0);
      checkOutput("rstTxd1", {31'd0, rTxd[1]}, 32'd1);
      @(negedge wClk);
      wRst = 1'b0;

      // Quiet line for 100 clocks.
      idleAct = 0;
      repeat (100) begin
         @(negedge wClk);
         if (rTxd[0] !== 1'b1 || rBusy[0] !== 1'b0 || rInReady[0] !== 1'b1) idleAct++;
      end
      checkOutput("idleActivity", idleAct, 32'd0);

      // 0xA5 frame: start bit one clock after acceptance, 4 clocks per level.
      $display("[TB] frame 0xA5");
      applyStimulus(0, 8'hA5);
      recordFrame(0, NB * 4 + 2, -1, 1'b0);
      seq = SEQ_A5;
      for (int i = 0; i < NB * 4; i++) checkOutput("a5Bit", {31'd0, recTxd[i]}, {31'd0, seq[i / 4]});
      checkOutput("a5BusyClocks", busyCnt, NB * 4);
      checkOutput("a5ReadyAtEnd", {31'd0, recReady[NB * 4]}, 32'd1);
      checkOutput("a5IdleAtEnd", {31'd0, recTxd[NB * 4]}, 32'd1);

      // Back-to-back 0x00 then 0xFF with wInValid held high.
      $display("[TB] back-to-back 0x00 / 0xFF");
      wInData[0]  = 8'h00;
      wInValid[0] = 1'b1;
      @(posedge wClk);
      @(negedge wClk);
      wInData[0] = 8'hFF;
      recordFrame(0, 2 * NB * 4 + 1, NB * 4 + 1, 1'b0);
      checkOutput("b2bReadyClocks", readyCnt, 32'd1);
      checkOutput("b2bReadyGap", {31'd0, recReady[NB * 4]}, 32'd1);
      checkOutput("b2bIdleMark", {31'd0, recTxd[NB * 4]}, 32'd1);
      checkOutput("b2bStart2", {31'd0, recTxd[NB * 4 + 1]}, 32'd0);
      checkOutput("b2bData00", {31'd0, recTxd[4]}, 32'd0);
      checkOutput("b2bDataFF", {31'd0, recTxd[NB * 4 + 1 + 4]}, 32'd1);
      checkOutput("b2bBusyClocks", busyCnt, 2 * NB * 4);
      repeat (NB * 4) @(negedge wClk);

      // Reset during data bit 3 of 0x0F, then 0x3C must go out intact.
      $display("[TB] reset mid-frame");
      applyStimulus(0, 8'h0F);
      repeat (17) @(negedge wClk);
      #2 wRst = 1'b1;
      #1;
      checkOutput("abortTxd", {31'd0, rTxd[0]}, 32'd1);
      checkOutput("abortReady", {31'd0, rInReady[0]}, 32'd1);
      checkOutput("abortBusy", {31'd0, rBusy[0]}, 32'd0);
      @(negedge wClk);
      @(negedge wClk);
      wRst = 1'b0;
      repeat (6) @(negedge wClk);
      checkOutput("noResumeBusy", {31'd0, rBusy[0]}, 32'd0);
      applyStimulus(0, 8'h3C);
      recordFrame(0, NB * 4 + 1, -1, 1'b0);
      seq = SEQ_3C;
      for (int i = 0; i < NB * 4; i++) checkOutput("x3cBit", {31'd0, recTxd[i]}, {31'd0, seq[i / 4]});
      checkOutput("x3cBusyClocks", busyCnt, NB * 4);

      // Slot 9 is the parity bit in 8E1 and the stop bit in 8N1.
      $display("[TB] parity slot 0x01 / 0x03");
      applyStimulus(0, 8'h01);
      recordFrame(0, NB * 4 + 1, -1, 1'b0);
      checkOutput("slot9x01", {31'd0, recTxd[9 * 4 + 1]}, {31'd0, SLOT9_01});
      checkOutput("frameLenx01", busyCnt, NB * 4);
      applyStimulus(0, 8'h03);
      recordFrame(0, NB * 4 + 1, -1, 1'b0);
      checkOutput("slot9x03", {31'd0, recTxd[9 * 4 + 1]}, {31'd0, SLOT9_03});
      checkOutput("frameLenx03", busyCnt, NB * 4);

      // Two clocks per bit, wInData flipping every clock during the frame.
      $display("[TB] 0x55 at 2 clocks per bit with toggling input");
      applyStimulus(1, 8'h55);
      recordFrame(1, NB * 2 + 1, -1, 1'b1);
      seq = SEQ_55;
      for (int i = 0; i < NB * 2; i++) checkOutput("x55Bit", {31'd0, recTxd[i]}, {31'd0, seq[i / 2]});
      checkOutput("x55BusyClocks", busyCnt, NB * 2);
      checkOutput("x55ReadyAtEnd", {31'd0, recReady[NB * 2]}, 32'd1);
      repeat (4) @(negedge wClk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
